// File: rtl/fetch_pkg.sv
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared types and ROM window constants for the fetch controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] ROM_BASE = 32'hBFC0_0000;
    localparam logic [31:0] ROM_SIZE = 32'h0000_1000;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Unsigned wrap makes addresses below ROM_BASE fail the window test too.
    function automatic logic pc_in_rom(input logic [31:0] addr);
        return ((addr - ROM_BASE) < ROM_SIZE) && (addr[1:0] == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Brief   : Synchronous prefetch FIFO with flush, parameterised on entry type.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  T                           push_data,
    output T                           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    T              mem_q [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full, push+pop writes the slot being vacated by the head.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module  : fetch_ctrl
// Brief   : Instruction fetch controller: PC, prefetch queue, redirect, fault.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;

    logic                     w_pc_ok;
    logic                     w_enq;
    logic                     w_deq;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(DEPTH):0]   w_count;
    fetch_entry_t             w_push_entry;
    fetch_entry_t             w_head;

    assign w_pc_ok     = pc_in_rom(fetch_pc_q);
    assign instr_valid = !w_empty && !redirect;
    assign w_deq       = instr_valid && instr_ready;
    assign w_enq       = (state_q == RUN) && w_pc_ok && !redirect && (!w_full || w_deq);

    always_comb begin
        w_push_entry.pc    = fetch_pc_q;
        w_push_entry.instr = mem_rdata;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            state_d    = RUN;
            fetch_pc_d = redirect_pc;
        end else if (state_q == RUN) begin
            if (!w_pc_ok) begin
                state_d = FAULT;
            end else if (w_enq) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_enq),
        .pop       (w_deq),
        .flush     (redirect),
        .push_data (w_push_entry),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Storage is not reset; mask the head so an empty queue presents zeros.
    assign instr    = (w_count != '0) ? w_head.instr : '0;
    assign instr_pc = (w_count != '0) ? w_head.pc    : '0;
    assign mem_addr = fetch_pc_q;
    assign fault    = (state_q == FAULT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module  : tb_fetch_ctrl
// Brief   : Directed + random bench for fetch_ctrl against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + ((a - 32'hBFC0_0000) >> 2);
    endfunction

    assign mem_rdata = rom_word(mem_addr);

    fetch_ctrl #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fault       (fault)
    );

    // Reference model: plain queues of delivered-but-not-consumed words.
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] q_pc [$];
    logic [31:0] q_ins [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= 32'hBFC0_0000) && (a <= 32'hBFC0_0FFF) && (a[1:0] == 2'b00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_ins.delete();
        m_pc    = RESET_PC;
        m_fault = 1'b0;
    endtask

    // Called just after a falling edge; checks, advances the model, waits a cycle.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic ev;
        logic d;
        logic room;
        redirect    = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;
        ev = (q_pc.size() != 0) && !rd;
        chk("valid", {31'b0, instr_valid}, {31'b0, ev});
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        chk("mem_addr", mem_addr, m_pc);
        if (ev) begin
            chk("instr_pc", instr_pc, q_pc[0]);
            chk("instr", instr, q_ins[0]);
        end
        d = ev && rdy;
        if (rd) begin
            q_pc.delete();
            q_ins.delete();
            m_pc    = rpc;
            m_fault = 1'b0;
        end else begin
            room = (q_pc.size() < DEPTH) || d;
            if (d) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (!m_fault) begin
                if (!in_window(m_pc)) begin
                    m_fault = 1'b1;
                end else if (room) begin
                    q_pc.push_back(m_pc);
                    q_ins.push_back(rom_word(m_pc));
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rpc;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        rst = 1'b0;

        // Stream from reset with ready high
        repeat (4) step(1'b0, '0, 1'b1);

        // Stall until queue saturates, then drain back-to-back
        step(1'b1, ROM_BASE, 1'b1);
        repeat (10) step(1'b0, '0, 1'b0);
        chk("stall_mem_addr", mem_addr, 32'hBFC0_0010);
        chk("stall_head_pc", instr_pc, 32'hBFC0_0000);
        repeat (6) step(1'b0, '0, 1'b1);

        // Redirect with a full queue
        repeat (5) step(1'b0, '0, 1'b0);
        step(1'b1, 32'hBFC0_0100, 1'b0);
        repeat (5) step(1'b0, '0, 1'b1);

        // Run off the end of the ROM window
        step(1'b1, 32'hBFC0_0FF8, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);
        chk("end_fault", {31'b0, fault}, 32'd1);
        chk("end_mem_addr", mem_addr, 32'hBFC0_1000);

        // Misaligned redirect re-faults; good redirect recovers
        step(1'b1, 32'hBFC0_0002, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        chk("misalign_fault", {31'b0, fault}, 32'd1);
        step(1'b1, 32'hBFC0_0040, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);

        // Asynchronous reset with three entries queued
        step(1'b1, ROM_BASE, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_rst_instr", instr, 32'd0);
        chk("async_rst_mem_addr", mem_addr, RESET_PC);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = ROM_BASE + 32'($urandom_range(0, 1023)) * 32'd4;
                1:       rpc = ROM_BASE + 32'hFF0 + 32'($urandom_range(0, 3)) * 32'd4;
                2:       rpc = ROM_BASE + (32'($urandom_range(0, 4095)) | 32'd1);
                default: rpc = $urandom;
            endcase
            step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
